// File: rtl/nonogram_line_solver.sv
// Nonogram line solver: filters one line's candidate options against the board,
// intersects the survivors to deduce cells, and tracks counts, contradiction and stall.
module nonogram_line_solver #(
  parameter int MAX_SIZE = 11,
  parameter int CNT_W    = 7,
  parameter int LINES    = 2*MAX_SIZE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          started,
  input  logic [3:0]                    num_rows,
  input  logic [3:0]                    num_cols,
  input  logic [LINES*CNT_W-1:0]        options_amnt_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_header,
  input  logic [MAX_SIZE-1:0]           in_data,
  output logic                          keep_valid,
  output logic                          put_back_to_FIFO,
  output logic                          line_done,
  output logic [4:0]                    line_idx,
  output logic [CNT_W-1:0]              line_count,
  output logic [MAX_SIZE*MAX_SIZE-1:0]  known,
  output logic [MAX_SIZE*MAX_SIZE-1:0]  assigned,
  output logic                          solved,
  output logic                          contradiction,
  output logic                          stalled
);
  localparam int CELLS = MAX_SIZE*MAX_SIZE;
  localparam int IW    = $clog2(CELLS);

  typedef enum logic [1:0] {IDLE, HDR, OPT, COMMIT} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt [LINES];
  logic [3:0]            r_rows, r_cols;
  logic [4:0]            r_line;
  logic                  r_is_row;
  logic [3:0]            r_pos, r_len;
  logic [CNT_W-1:0]      r_remaining, r_surv;
  logic [MAX_SIZE-1:0]   r_acc_one, r_acc_zero;
  logic [CELLS-1:0]      r_known, r_assigned;
  logic [4:0]            r_stall_cnt;
  logic                  r_keep_valid, r_put_back, r_line_done, r_contra, r_stalled;
  logic [4:0]            r_line_idx;
  logic [CNT_W-1:0]      r_line_count;

  logic [MAX_SIZE-1:0][IW-1:0] w_idx;
  logic [MAX_SIZE-1:0]   w_in, w_line_known, w_line_asg;
  logic [CELLS-1:0]      w_one_cells, w_zero_cells, w_active;
  logic                  w_conflict, w_new_known;
  logic [4:0]            w_total, w_hdr_line;
  logic                  w_hdr_is_row;
  logic [3:0]            w_hdr_pos;
  logic [CNT_W-1:0]      w_hdr_cnt;

  assign w_total      = {1'b0, r_rows} + {1'b0, r_cols};
  assign w_hdr_line   = in_data[4:0];
  assign w_hdr_is_row = w_hdr_line < {1'b0, r_rows};
  assign w_hdr_pos    = w_hdr_is_row ? w_hdr_line[3:0] : (w_hdr_line[3:0] - r_rows);
  assign w_hdr_cnt    = (int'(w_hdr_line) < LINES) ? r_cnt[w_hdr_line] : '0;

  // Map position i along the current line to its board cell.
  for (genvar i = 0; i < MAX_SIZE; i++) begin : g_cell
    assign w_idx[i]        = r_is_row ? IW'(int'(r_pos)*MAX_SIZE + i)
                                      : IW'(i*MAX_SIZE + int'(r_pos));
    assign w_in[i]         = (i < int'(r_len));
    assign w_line_known[i] = w_in[i] & r_known[w_idx[i]];
    assign w_line_asg[i]   = r_assigned[w_idx[i]];
  end

  always_comb begin
    w_one_cells  = '0;
    w_zero_cells = '0;
    for (int i = 0; i < MAX_SIZE; i++) begin
      if (w_in[i]) begin
        w_one_cells[w_idx[i]]  = r_acc_one[i];
        w_zero_cells[w_idx[i]] = r_acc_zero[i];
      end
    end
  end

  always_comb begin
    w_active = '0;
    for (int r = 0; r < MAX_SIZE; r++)
      for (int c = 0; c < MAX_SIZE; c++)
        w_active[r*MAX_SIZE+c] = (r < int'(r_rows)) && (c < int'(r_cols));
  end

  assign w_conflict  = |(w_line_known & (w_line_asg ^ in_data));
  assign w_new_known = (r_surv != '0) && |((w_one_cells | w_zero_cells) & ~r_known);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      for (int i = 0; i < LINES; i++) r_cnt[i] <= '0;
      r_rows       <= '0;
      r_cols       <= '0;
      r_line       <= '0;
      r_is_row     <= 1'b0;
      r_pos        <= '0;
      r_len        <= '0;
      r_remaining  <= '0;
      r_surv       <= '0;
      r_acc_one    <= '0;
      r_acc_zero   <= '0;
      r_known      <= '0;
      r_assigned   <= '0;
      r_stall_cnt  <= '0;
      r_keep_valid <= 1'b0;
      r_put_back   <= 1'b0;
      r_line_done  <= 1'b0;
      r_line_idx   <= '0;
      r_line_count <= '0;
      r_contra     <= 1'b0;
      r_stalled    <= 1'b0;
    end else begin
      r_keep_valid <= 1'b0;
      r_line_done  <= 1'b0;
      if (started) begin
        r_state     <= HDR;
        r_rows      <= num_rows;
        r_cols      <= num_cols;
        for (int i = 0; i < LINES; i++) r_cnt[i] <= options_amnt_in[i*CNT_W +: CNT_W];
        r_known     <= '0;
        r_assigned  <= '0;
        r_contra    <= 1'b0;
        r_stall_cnt <= '0;
        r_stalled   <= 1'b0;
      end else begin
        case (r_state)
          HDR: if (in_valid && in_header && w_hdr_cnt != '0 && w_hdr_line < w_total) begin
            r_line      <= w_hdr_line;
            r_is_row    <= w_hdr_is_row;
            r_pos       <= w_hdr_pos;
            r_len       <= w_hdr_is_row ? r_cols : r_rows;
            r_remaining <= w_hdr_cnt;
            r_acc_one   <= '1;
            r_acc_zero  <= '1;
            r_surv      <= '0;
            r_state     <= OPT;
          end
          OPT: if (in_valid && !in_header) begin
            r_keep_valid <= 1'b1;
            r_put_back   <= !w_conflict;
            if (!w_conflict) begin
              r_surv     <= r_surv + CNT_W'(1);
              r_acc_one  <= r_acc_one & in_data;
              r_acc_zero <= r_acc_zero & ~in_data;
            end
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) r_state <= COMMIT;
          end
          COMMIT: begin
            if (int'(r_line) < LINES) r_cnt[r_line] <= r_surv;
            r_line_done  <= 1'b1;
            r_line_idx   <= r_line;
            r_line_count <= r_surv;
            if (r_surv != '0) begin
              r_known    <= r_known | w_one_cells | w_zero_cells;
              r_assigned <= (r_assigned | w_one_cells) & ~w_zero_cells;
            end else begin
              r_contra   <= 1'b1;
            end
            // Stall counter saturates at one full pass of lines.
            if (w_new_known) begin
              r_stall_cnt <= '0;
              r_stalled   <= 1'b0;
            end else if (r_stall_cnt != w_total) begin
              r_stall_cnt <= r_stall_cnt + 5'd1;
              r_stalled   <= (r_stall_cnt + 5'd1) == w_total;
            end
            r_state <= HDR;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready         = (r_state == HDR) || (r_state == OPT);
  assign keep_valid       = r_keep_valid;
  assign put_back_to_FIFO = r_put_back;
  assign line_done        = r_line_done;
  assign line_idx         = r_line_idx;
  assign line_count       = r_line_count;
  assign known            = r_known;
  assign assigned         = r_assigned;
  assign contradiction    = r_contra;
  assign stalled          = r_stalled;
  assign solved           = (r_rows != '0) && (r_cols != '0) && ((r_known & w_active) == w_active);
endmodule

// File: tb/tb_nonogram_line_solver.sv
// Bench for nonogram_line_solver: directed scenarios plus random boards checked
// against a 2-D board model that applies the line-filtering rules directly.
module tb_nonogram_line_solver;
  localparam int MS = 11, CW = 7, NL = 2*MS, NC = MS*MS;

  logic clk = 1'b0, rst = 1'b0, started = 1'b0;
  logic [3:0] num_rows = '0, num_cols = '0;
  logic [NL*CW-1:0] options_amnt_in = '0;
  logic in_valid = 1'b0, in_ready, in_header = 1'b0;
  logic [MS-1:0] in_data = '0;
  logic keep_valid, put_back_to_FIFO, line_done, solved, contradiction, stalled;
  logic [4:0] line_idx;
  logic [CW-1:0] line_count;
  logic [NC-1:0] known, assigned;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  nonogram_line_solver #(.MAX_SIZE(MS), .CNT_W(CW), .LINES(NL)) dut (
    .clk(clk), .rst(rst), .started(started), .num_rows(num_rows), .num_cols(num_cols),
    .options_amnt_in(options_amnt_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_header(in_header), .in_data(in_data), .keep_valid(keep_valid),
    .put_back_to_FIFO(put_back_to_FIFO), .line_done(line_done), .line_idx(line_idx),
    .line_count(line_count), .known(known), .assigned(assigned), .solved(solved),
    .contradiction(contradiction), .stalled(stalled));

  typedef struct { int idx; int cnt; logic [NC-1:0] k; logic [NC-1:0] a; logic sol; logic con; logic stl; } done_t;
  logic  keep_q[$];
  done_t done_q[$];

  always @(negedge clk) begin
    done_t d;
    if (keep_valid) keep_q.push_back(put_back_to_FIFO);
    if (line_done) begin
      d.idx = int'(line_idx); d.cnt = int'(line_count); d.k = known; d.a = assigned;
      d.sol = solved; d.con = contradiction; d.stl = stalled;
      done_q.push_back(d);
    end
  end

  // Board model: -1 unknown, else the cell value.
  int mb [MS][MS];
  int mcnt [NL];
  int mrows, mcols, mstall;
  logic mcon, mstl;
  logic [MS-1:0] g_opts[$];
  bit g_stray = 0;

  function automatic void line_cell(input int L, input int i, output int r, output int c);
    if (L < mrows) begin r = L; c = i; end
    else begin r = i; c = L - mrows; end
  endfunction

  function automatic logic [NC-1:0] mk_known();
    logic [NC-1:0] v = '0;
    for (int r = 0; r < MS; r++) for (int c = 0; c < MS; c++) if (mb[r][c] >= 0) v[r*MS+c] = 1'b1;
    return v;
  endfunction

  function automatic logic [NC-1:0] mk_asg();
    logic [NC-1:0] v = '0;
    for (int r = 0; r < MS; r++) for (int c = 0; c < MS; c++) if (mb[r][c] == 1) v[r*MS+c] = 1'b1;
    return v;
  endfunction

  function automatic logic mk_solved();
    for (int r = 0; r < mrows; r++) for (int c = 0; c < mcols; c++) if (mb[r][c] < 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send(input logic hdr, input logic [MS-1:0] d);
    int t = 0;
    in_valid = 1'b1; in_header = hdr; in_data = d;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL ready_timeout: in_ready stuck at %b, need 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_header = 1'b0;
  endtask

  task automatic do_start(input int rows, input int cols);
    mrows = rows; mcols = cols; mcon = 0; mstall = 0; mstl = 0;
    for (int r = 0; r < MS; r++) for (int c = 0; c < MS; c++) mb[r][c] = -1;
    num_rows = 4'(rows); num_cols = 4'(cols);
    for (int i = 0; i < NL; i++) options_amnt_in[i*CW +: CW] = CW'(mcnt[i]);
    started = 1'b1; @(posedge clk); #1; started = 1'b0;
    keep_q.delete(); done_q.delete();
  endtask

  // Drive one line (header + g_opts) and check verdicts and commit against the model.
  task automatic run_line(input int L);
    int len, n, surv, r, c, t;
    logic [MS-1:0] opt, acc1, acc0;
    logic exp_keep[$];
    logic got;
    bit cf, newk;
    done_t d;
    send(1'b1, MS'(L));
    if (L >= mrows + mcols || mcnt[L] == 0) begin
      repeat (4) @(posedge clk); #1;
      checks++;
      if (done_q.size() !== 0 || keep_q.size() !== 0) begin
        errors++;
        $display("FAIL ignored_line %0d: done=%0d keep=%0d events, need 0", L, done_q.size(), keep_q.size());
      end
      return;
    end
    len = (L < mrows) ? mcols : mrows;
    n = mcnt[L]; surv = 0; acc1 = '1; acc0 = '1;
    for (int k = 0; k < n; k++) begin
      opt = g_opts[k]; cf = 0;
      for (int i = 0; i < len; i++) begin
        line_cell(L, i, r, c);
        if (mb[r][c] >= 0 && mb[r][c] != int'(opt[i])) cf = 1;
      end
      exp_keep.push_back(!cf);
      if (!cf) begin surv++; acc1 &= opt; acc0 &= ~opt; end
      send(1'b0, opt);
      if (g_stray && k == 0 && n > 1) send(1'b1, MS'(L));
    end
    t = 0;
    while (done_q.size() == 0 && t < 20) begin @(posedge clk); #1; t++; end
    checks++;
    if (done_q.size() == 0) begin
      errors++; $display("FAIL line_done_timeout line %0d: no pulse, need one", L); return;
    end
    foreach (exp_keep[k]) begin
      checks++;
      got = (keep_q.size() > 0) ? keep_q.pop_front() : 1'bx;
      if (got !== exp_keep[k]) begin
        errors++; $display("FAIL keep line %0d opt %0d: got %b need %b", L, k, got, exp_keep[k]);
      end
    end
    mcnt[L] = surv; newk = 0;
    if (surv == 0) mcon = 1;
    else for (int i = 0; i < len; i++) begin
      line_cell(L, i, r, c);
      if (acc1[i]) begin if (mb[r][c] < 0) newk = 1; mb[r][c] = 1; end
      else if (acc0[i]) begin if (mb[r][c] < 0) newk = 1; mb[r][c] = 0; end
    end
    if (newk) mstall = 0; else if (mstall < mrows + mcols) mstall++;
    mstl = (mstall == mrows + mcols);
    d = done_q.pop_front();
    checks++;
    if (d.idx !== L || d.cnt !== surv) begin
      errors++; $display("FAIL commit line %0d: idx=%0d cnt=%0d need idx=%0d cnt=%0d", L, d.idx, d.cnt, L, surv);
    end
    checks++;
    if (d.k !== mk_known() || d.a !== mk_asg()) begin
      errors++; $display("FAIL board line %0d: known=%h asg=%h need known=%h asg=%h", L, d.k, d.a, mk_known(), mk_asg());
    end
    checks++;
    if (d.sol !== mk_solved() || d.con !== mcon || d.stl !== mstl) begin
      errors++; $display("FAIL flags line %0d: sol/con/stl=%b%b%b need %b%b%b", L, d.sol, d.con, d.stl, mk_solved(), mcon, mstl);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) @(posedge clk); #1; rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || keep_valid !== 1'b0 || line_done !== 1'b0 || put_back_to_FIFO !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: rdy/keep/done/pb=%b%b%b%b need 0000", in_ready, keep_valid, line_done, put_back_to_FIFO);
    end
    checks++;
    if (known !== '0 || assigned !== '0 || line_idx !== '0 || line_count !== '0) begin
      errors++; $display("FAIL reset_board: known=%h asg=%h need 0", known, assigned);
    end
    checks++;
    if (solved !== 1'b0 || contradiction !== 1'b0 || stalled !== 1'b0) begin
      errors++; $display("FAIL reset_flags: %b%b%b need 000", solved, contradiction, stalled);
    end
  endtask

  task automatic test_basic();
    mcnt = '{default: 0}; mcnt[0] = 1; mcnt[1] = 1; mcnt[2] = 2; mcnt[3] = 2; mcnt[4] = 2;
    do_start(2, 3);
    g_opts = '{11'b111}; run_line(0);
    g_opts = '{11'b000}; run_line(1);
    g_opts = '{11'b01, 11'b10}; run_line(2);
    g_opts = '{11'b01, 11'b11}; run_line(3);
    g_opts = '{11'b10, 11'b01}; run_line(4);
    checks++;
    if (solved !== 1'b1) begin errors++; $display("FAIL basic_solved: got %b need 1", solved); end
  endtask

  task automatic test_intersect();
    mcnt = '{default: 0}; for (int i = 0; i < 5; i++) mcnt[i] = 2;
    do_start(2, 3);
    g_opts = '{11'b110, 11'b011}; run_line(0);
    checks++;
    if (known !== NC'(2) || assigned !== NC'(2)) begin
      errors++; $display("FAIL intersect: known=%h asg=%h need 2/2", known, assigned);
    end
  endtask

  task automatic test_conflict();
    mcnt = '{default: 0}; for (int i = 0; i < 5; i++) mcnt[i] = 2;
    do_start(2, 3);
    g_opts = '{11'b111, 11'b111}; run_line(0);
    g_opts = '{11'b100, 11'b010}; run_line(0);
    run_line(0);
    run_line(7);
    checks++;
    if (contradiction !== 1'b1) begin errors++; $display("FAIL contradiction_sticky: got %b need 1", contradiction); end
  endtask

  task automatic test_stall();
    mcnt = '{default: 0}; for (int i = 0; i < 5; i++) mcnt[i] = 2;
    do_start(2, 3);
    for (int L = 0; L < 5; L++) begin
      g_opts = (L < 2) ? '{11'b101, 11'b010} : '{11'b01, 11'b10};
      run_line(L);
    end
    checks++;
    if (stalled !== 1'b1) begin errors++; $display("FAIL stall_set: got %b need 1", stalled); end
    g_opts = '{11'b101, 11'b101}; run_line(0);
    checks++;
    if (stalled !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b need 0", stalled); end
  endtask

  task automatic test_handshake();
    mcnt = '{default: 0}; mcnt[0] = 1; for (int i = 1; i < 5; i++) mcnt[i] = 2;
    do_start(2, 3);
    send(1'b1, 11'd0); send(1'b0, 11'b111);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL commit_ready: got %b need 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || known[2:0] !== 3'b111) begin
      errors++; $display("FAIL post_commit: rdy=%b known=%b need 1/111", in_ready, known[2:0]);
    end
    do_start(2, 3);
    send(1'b0, 11'b101);
    g_stray = 1; g_opts = '{11'b111, 11'b011}; run_line(1); g_stray = 0;
    // Reset in the middle of a line.
    send(1'b1, 11'd2); send(1'b0, 11'b01);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || keep_valid !== 1'b0 || known !== '0 || contradiction !== 1'b0 || stalled !== 1'b0) begin
      errors++; $display("FAIL mid_reset: rdy=%b keep=%b known=%h need 0", in_ready, keep_valid, known);
    end
    mcnt = '{default: 0}; mcnt[0] = 1; for (int i = 1; i < 5; i++) mcnt[i] = 2;
    do_start(2, 3);
    g_opts = '{11'b111}; run_line(0);
    send(1'b1, 11'd1); send(1'b0, 11'b000);
    do_start(2, 3);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (known !== '0 || done_q.size() !== 0) begin
      errors++; $display("FAIL restart_mid_line: known=%h done=%0d need 0/0", known, done_q.size());
    end
  endtask

  task automatic test_random();
    int sol [MS][MS];
    int rows, cols, total, len, r, c;
    logic [MS-1:0] o;
    for (int b = 0; b < 6; b++) begin
      rows = $urandom_range(1, MS); cols = $urandom_range(1, MS); total = rows + cols;
      for (int i = 0; i < MS; i++) for (int j = 0; j < MS; j++) sol[i][j] = $urandom_range(0, 1);
      for (int i = 0; i < NL; i++) mcnt[i] = $urandom_range(1, 4);
      do_start(rows, cols);
      for (int p = 0; p < 3; p++) begin
        for (int L = 0; L < total; L++) begin
          len = (L < rows) ? cols : rows;
          g_opts.delete();
          for (int k = 0; k < mcnt[L]; k++) begin
            o = MS'($urandom);
            if ($urandom_range(0, 9) < 6)
              for (int i = 0; i < len; i++) begin line_cell(L, i, r, c); o[i] = sol[r][c][0]; end
            g_opts.push_back(o);
          end
          run_line(L);
        end
        if (total < 31) begin g_opts.delete(); run_line($urandom_range(total, 31)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_intersect();
    test_conflict();
    test_stall();
    test_handshake();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nonogram_line_solver.md
Name: nonogram_line_solver

Overview:
- Parametrised successor of the fixed-size line solver: consumes one nonogram line at a time (line header, then that line's candidate options from the option FIFO) and filters options against the current board.
- Intersects the surviving options to deduce newly known cells and tracks per-line option counts internally.
- Adds contradiction detection, stall detection and a valid/ready input handshake.
- Sits between the option FIFO and the board/solution output logic.

Parameters:
MAX_SIZE, 11, maximum rows/columns; board is MAX_SIZE*MAX_SIZE cells, cell (r,c) at bit r*MAX_SIZE+c
CNT_W, 7, width of a per-line option count
LINES, 2*MAX_SIZE, number of line slots; row r = index r, column c = index num_rows+c

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
started  in  1  one-cycle pulse: clear board, load counts, begin solving
num_rows  in  4  active rows (1..MAX_SIZE), sampled on started
num_cols  in  4  active columns (1..MAX_SIZE), sampled on started
options_amnt_in  in  LINES*CNT_W  initial option count per line, slot i at [i*CNT_W +: CNT_W], sampled on started
in_valid  in  1  input beat valid
in_ready  out  1  solver can accept a beat
in_header  in  1  beat is a line header (line index in low bits of in_data)
in_data  in  MAX_SIZE  line index (header) or option; bit i = cell i along the line
keep_valid  out  1  one-cycle pulse, verdict on the previous option beat
put_back_to_FIFO  out  1  verdict: 1 = option survives, re-queue it; 0 = drop
line_done  out  1  one-cycle pulse, line committed
line_idx  out  5  index of the committed line
line_count  out  CNT_W  surviving option count of the committed line
known  out  MAX_SIZE*MAX_SIZE  cell determined
assigned  out  MAX_SIZE*MAX_SIZE  cell value, meaningful where known=1
solved  out  1  every active cell known
contradiction  out  1  sticky: some line had zero survivors
stalled  out  1  a full pass of num_rows+num_cols committed lines produced no new known cell

Behaviour:
- Reset: all outputs 0, all counts 0, state IDLE, in_ready=0. rst has priority over started and over any in-progress line.
- started, in any state: known=0, assigned=0, counts loaded, sticky flags cleared, stall counter=0, state HDR. An in-progress line is abandoned without line_done.
- in_ready=1 in HDR and OPT, 0 in IDLE and COMMIT. A beat is accepted when in_valid&&in_ready.
- HDR, header beat accepted: L = in_data[4:0], line length = num_cols for a row, num_rows for a column.
  - count[L]==0, or L >= num_rows+num_cols: line is ignored, stay in HDR, no line_done.
  - Otherwise: remaining = count[L], acc_one = all ones, acc_zero = all ones, survivors = 0, state OPT.
  - A non-header beat in HDR is discarded.
- OPT, option beat accepted:
  - Conflict = any in-length cell known with assigned != option bit. Bits beyond the line length are ignored.
  - Next cycle: keep_valid=1, put_back_to_FIFO = !conflict.
  - Non-conflicting option: survivors++, acc_one &= opt, acc_zero &= ~opt.
  - Every accepted option: remaining--. When remaining reaches 0, go to COMMIT.
  - A header beat in OPT is a protocol error: the beat is discarded and the state is unchanged.
- COMMIT, one cycle:
  - count[L] = survivors; line_done=1 with line_idx=L, line_count=survivors.
  - If survivors>0, for each in-length cell: acc_one bit sets known=1, assigned=1; acc_zero bit sets known=1, assigned=0.
  - If survivors==0: contradiction=1, board unchanged.
  - Updated known/assigned are visible the cycle after COMMIT.
  - Next state HDR.
- Stall counter: reset on any commit that sets a new known bit, otherwise incremented. stalled=1 when counter == num_rows+num_cols (saturates).
- solved is combinational from known over rows < num_rows and columns < num_cols. Cells outside the active region are never written.
- Throughput: one option per cycle. Per-line overhead: header cycle plus one COMMIT cycle.

Test Plan:
1. 2x3 board, counts {1,1,2,2,2}, started; row0 header + 3'b111 -> keep=1, line_done idx0 count1, known row0 = 111, assigned = 111.
2. Continue: row1 header + 3'b000 -> row1 known = 111, assigned = 000; col0 header, options 2'b01 then 2'b10 -> first keep=1, second keep=0 (cell (0,0)=1), count 1; solved=1 after col2.
3. Row0 known 111/111, then row0 header with count 2 (fresh started, counts {2,...}), options 3'b110 and 3'b011 -> acc_one = 010, acc_zero = 000: only cell (0,1) becomes known=1, assigned=1.
4. Conflict: board row0 = 111, row0 count 2, options 3'b100, 3'b010 both conflicting -> keep=0 twice, line_count=0, contradiction=1, board unchanged.
5. Stall: 2x3 board with all lines ambiguous (every line two complementary options), commit all 5 lines with no new knowns -> stalled asserts on the 5th line_done; a later line that adds a known cell clears the counter.
6. Handshake/reset: in_valid held with stalls during COMMIT (in_ready=0 for 1 cycle, no beat lost); rst mid-OPT -> all outputs 0, in_ready=0 next cycle; started during OPT -> board cleared, no line_done.
